// File: rtl/rt_gray_pkg.sv
// Shared types for the gray-count transition monitor: FSM states, error codes
// and a reference gray-to-binary helper.
package rt_gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    EC_NONE   = 2'b00,
    EC_NONADJ = 2'b01,
    EC_MULTI  = 2'b10
  } err_code_e;

  localparam int unsigned GRAY_MAX_W = 64;

  // Each binary bit is the XOR of the gray bits at and above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rt_gray2bin.sv
// Combinational gray-to-binary decoder of configurable width.
module rt_gray2bin #(
  parameter int unsigned PARAM_BIT_NUM = 32
) (
  input  logic [PARAM_BIT_NUM-1:0] rt_i_gray,
  output logic [PARAM_BIT_NUM-1:0] rt_o_bin
);

  always_comb begin
    rt_o_bin = '0;
    for (int i = 0; i < PARAM_BIT_NUM; i++) begin
      rt_o_bin[i] = ^(rt_i_gray >> i);
    end
  end

endmodule

// File: rtl/rt_gray_mon.sv
// Gray-count transition monitor: classifies each accepted step as hold/up/down/
// illegal, keeps saturating error statistics and a first-error snapshot.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no reference yet; next valid sample becomes the reference
//  ST_TRACK | reference held; each valid sample is checked against it
//  ST_HALT  | stopped after an error (stop-on-error build); only clr exits
module rt_gray_mon
  import rt_gray_pkg::*;
#(
  parameter int unsigned PARAM_BIT_NUM     = 32,
  parameter int unsigned PARAM_ERR_CNT_W   = 16,
  parameter bit          PARAM_STOP_ON_ERR = 1'b0
) (
  input  logic                       rt_i_clk,
  input  logic                       rt_i_rst_n,
  input  logic                       rt_i_clr,
  input  logic                       rt_i_ld,
  input  logic                       rt_i_vld,
  input  logic [PARAM_BIT_NUM-1:0]   rt_i_gray,
  output logic [PARAM_BIT_NUM-1:0]   rt_o_bin,
  output logic                       rt_o_up,
  output logic                       rt_o_dn,
  output logic                       rt_o_err,
  output logic [1:0]                 rt_o_err_code,
  output logic                       rt_o_err_sticky,
  output logic [PARAM_ERR_CNT_W-1:0] rt_o_err_cnt,
  output logic [PARAM_BIT_NUM-1:0]   rt_o_snap_prev,
  output logic [PARAM_BIT_NUM-1:0]   rt_o_snap_cur,
  output logic [1:0]                 rt_o_state
);

  localparam logic [PARAM_BIT_NUM-1:0]   ONE_N = {{(PARAM_BIT_NUM-1){1'b0}}, 1'b1};
  localparam logic [PARAM_ERR_CNT_W-1:0] ONE_W = {{(PARAM_ERR_CNT_W-1){1'b0}}, 1'b1};

  state_e                     state_q;
  err_code_e                  err_code_q;
  logic [PARAM_BIT_NUM-1:0]   ref_gray_q;
  logic [PARAM_BIT_NUM-1:0]   bin_q;
  logic                       up_q, dn_q, err_q, sticky_q;
  logic [PARAM_ERR_CNT_W-1:0] cnt_q;
  logic [PARAM_BIT_NUM-1:0]   snap_prev_q, snap_cur_q;

  logic [PARAM_BIT_NUM-1:0]   cur_bin;
  logic [PARAM_BIT_NUM-1:0]   diff;
  logic [PARAM_BIT_NUM-1:0]   gray_xor;
  logic                       is_hold, is_up, is_dn, is_multi;

  rt_gray2bin #(.PARAM_BIT_NUM(PARAM_BIT_NUM)) u_dec (
    .rt_i_gray (rt_i_gray),
    .rt_o_bin  (cur_bin)
  );

  // bin_q doubles as the decoded reference, so the step is a plain subtraction.
  assign diff     = cur_bin - bin_q;
  assign gray_xor = rt_i_gray ^ ref_gray_q;
  assign is_hold  = (diff == '0);
  assign is_up    = (diff == ONE_N);
  assign is_dn    = (diff == '1);
  assign is_multi = |(gray_xor & (gray_xor - ONE_N));

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      state_q     <= ST_IDLE;
      err_code_q  <= EC_NONE;
      ref_gray_q  <= '0;
      bin_q       <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      snap_prev_q <= '0;
      snap_cur_q  <= '0;
    end else begin
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      err_q <= 1'b0;
      if (rt_i_clr) begin
        state_q     <= ST_IDLE;
        err_code_q  <= EC_NONE;
        sticky_q    <= 1'b0;
        cnt_q       <= '0;
        snap_prev_q <= '0;
        snap_cur_q  <= '0;
      end else if (state_q != ST_HALT) begin
        if (rt_i_ld) begin
          if (rt_i_vld) begin
            ref_gray_q <= rt_i_gray;
            bin_q      <= cur_bin;
            state_q    <= ST_TRACK;
          end else begin
            state_q <= ST_IDLE;
          end
        end else if (rt_i_vld) begin
          ref_gray_q <= rt_i_gray;
          bin_q      <= cur_bin;
          if (state_q == ST_IDLE) begin
            state_q <= ST_TRACK;
          end else if (is_up) begin
            up_q <= 1'b1;
          end else if (is_dn) begin
            dn_q <= 1'b1;
          end else if (!is_hold) begin
            err_q      <= 1'b1;
            sticky_q   <= 1'b1;
            err_code_q <= is_multi ? EC_MULTI : EC_NONADJ;
            if (cnt_q != '1) cnt_q <= cnt_q + ONE_W;
            if (!sticky_q) begin
              snap_prev_q <= ref_gray_q;
              snap_cur_q  <= rt_i_gray;
            end
            if (PARAM_STOP_ON_ERR) state_q <= ST_HALT;
          end
        end
      end
    end
  end

  assign rt_o_bin        = bin_q;
  assign rt_o_up         = up_q;
  assign rt_o_dn         = dn_q;
  assign rt_o_err        = err_q;
  assign rt_o_err_code   = err_code_q;
  assign rt_o_err_sticky = sticky_q;
  assign rt_o_err_cnt    = cnt_q;
  assign rt_o_snap_prev  = snap_prev_q;
  assign rt_o_snap_cur   = snap_cur_q;
  assign rt_o_state      = state_q;

endmodule

// File: tb/tb_rt_gray_mon.sv
// Bench for rt_gray_mon: two instances (resync and stop-on-error) share stimulus
// and are checked every cycle against an arithmetic model plus literal spot checks.
module tb_rt_gray_mon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, vld = 1'b0;
  logic [3:0] gray = 4'b0;

  logic [3:0] o_bin [2];
  logic       o_up [2], o_dn [2], o_err [2], o_sticky [2];
  logic [1:0] o_code [2], o_state [2];
  logic [3:0] o_cnt [2], o_sp [2], o_sc [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance (index 0: resync build, 1: stop-on-error build)
  int m_st [2], m_bin [2], m_rg [2], m_up [2], m_dn [2], m_err [2];
  int m_code [2], m_sticky [2], m_cnt [2], m_sp [2], m_sc [2];

  always #5 clk = ~clk;

  rt_gray_mon #(.PARAM_BIT_NUM(4), .PARAM_ERR_CNT_W(4), .PARAM_STOP_ON_ERR(1'b0)) u_dut0 (
    .rt_i_clk(clk), .rt_i_rst_n(rst_n), .rt_i_clr(clr), .rt_i_ld(ld), .rt_i_vld(vld),
    .rt_i_gray(gray), .rt_o_bin(o_bin[0]), .rt_o_up(o_up[0]), .rt_o_dn(o_dn[0]),
    .rt_o_err(o_err[0]), .rt_o_err_code(o_code[0]), .rt_o_err_sticky(o_sticky[0]),
    .rt_o_err_cnt(o_cnt[0]), .rt_o_snap_prev(o_sp[0]), .rt_o_snap_cur(o_sc[0]),
    .rt_o_state(o_state[0]));

  rt_gray_mon #(.PARAM_BIT_NUM(4), .PARAM_ERR_CNT_W(4), .PARAM_STOP_ON_ERR(1'b1)) u_dut1 (
    .rt_i_clk(clk), .rt_i_rst_n(rst_n), .rt_i_clr(clr), .rt_i_ld(ld), .rt_i_vld(vld),
    .rt_i_gray(gray), .rt_o_bin(o_bin[1]), .rt_o_up(o_up[1]), .rt_o_dn(o_dn[1]),
    .rt_o_err(o_err[1]), .rt_o_err_code(o_code[1]), .rt_o_err_sticky(o_sticky[1]),
    .rt_o_err_cnt(o_cnt[1]), .rt_o_snap_prev(o_sp[1]), .rt_o_snap_cur(o_sc[1]),
    .rt_o_state(o_state[1]));

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < 4; s++) b = b ^ (g >> s);
    return b & 15;
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = 0; m_bin[k] = 0; m_rg[k] = 0; m_up[k] = 0; m_dn[k] = 0; m_err[k] = 0;
    m_code[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0; m_sp[k] = 0; m_sc[k] = 0;
  endtask

  task automatic model_step(input int k);
    int cur, d;
    cur = g2b(int'(gray));
    m_up[k] = 0; m_dn[k] = 0; m_err[k] = 0;
    if (clr) begin
      m_st[k] = 0; m_code[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0; m_sp[k] = 0; m_sc[k] = 0;
    end else if (m_st[k] != 2) begin
      if (ld) begin
        if (vld) begin m_rg[k] = int'(gray); m_bin[k] = cur; m_st[k] = 1; end
        else m_st[k] = 0;
      end else if (vld) begin
        if (m_st[k] == 0) m_st[k] = 1;
        else begin
          d = (cur - m_bin[k] + 16) % 16;
          if (d == 1) m_up[k] = 1;
          else if (d == 15) m_dn[k] = 1;
          else if (d != 0) begin
            m_err[k] = 1;
            m_code[k] = ($countones(4'(m_rg[k] ^ int'(gray))) > 1) ? 2 : 1;
            if (m_sticky[k] == 0) begin m_sp[k] = m_rg[k]; m_sc[k] = int'(gray); end
            m_sticky[k] = 1;
            if (m_cnt[k] < 15) m_cnt[k] = m_cnt[k] + 1;
            if (k == 1) m_st[k] = 2;
          end
        end
        m_rg[k] = int'(gray); m_bin[k] = cur;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin model_reset(0); model_reset(1); end
    else begin model_step(0); model_step(1); end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bin%0d", k),    32'(o_bin[k]),    m_bin[k]);
      chk($sformatf("up%0d", k),     32'(o_up[k]),     m_up[k]);
      chk($sformatf("dn%0d", k),     32'(o_dn[k]),     m_dn[k]);
      chk($sformatf("err%0d", k),    32'(o_err[k]),    m_err[k]);
      chk($sformatf("code%0d", k),   32'(o_code[k]),   m_code[k]);
      chk($sformatf("sticky%0d", k), 32'(o_sticky[k]), m_sticky[k]);
      chk($sformatf("cnt%0d", k),    32'(o_cnt[k]),    m_cnt[k]);
      chk($sformatf("sprev%0d", k),  32'(o_sp[k]),     m_sp[k]);
      chk($sformatf("scur%0d", k),   32'(o_sc[k]),     m_sc[k]);
      chk($sformatf("state%0d", k),  32'(o_state[k]),  m_st[k]);
    end
  end

  task automatic step(input logic c, input logic l, input logic v, input logic [3:0] g);
    @(negedge clk); #1;
    clr = c; ld = l; vld = v; gray = g;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_state", 32'(o_state[0]), 0);
    chk("rst_bin",   32'(o_bin[0]),   0);

    // 1: counting up from 0
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0000);
    chk("t1_ref_noup", 32'(o_up[0]), 0);
    step(0, 0, 1, 4'b0001);
    chk("t1_up2", 32'(o_up[0]), 1);
    step(0, 0, 1, 4'b0011);
    step(0, 0, 1, 4'b0010);
    chk("t1_bin", 32'(o_bin[0]), 3);
    chk("t1_up4", 32'(o_up[0]), 1);
    chk("t1_state", 32'(o_state[0]), 1);
    step(0, 0, 0, 4'b0010);
    chk("t1_nostretch", 32'(o_up[0]), 0);
    chk("t1_noerr", 32'(o_err_sticky_any()), 0);

    // 2: wrap both ways
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b1000);
    step(0, 0, 1, 4'b0000);
    chk("t2_up", 32'(o_up[0]), 1);
    chk("t2_bin0", 32'(o_bin[0]), 0);
    step(0, 0, 1, 4'b1000);
    chk("t2_dn", 32'(o_dn[0]), 1);
    chk("t2_bin15", 32'(o_bin[0]), 15);

    // 3: multi-bit error and resync
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 1, 4'b0011);
    chk("t3_err", 32'(o_err[0]), 1);
    chk("t3_code", 32'(o_code[0]), 2);
    chk("t3_cnt", 32'(o_cnt[0]), 1);
    chk("t3_sprev", 32'(o_sp[0]), 0);
    chk("t3_scur", 32'(o_sc[0]), 3);
    chk("t3_halt", 32'(o_state[1]), 2);
    step(0, 0, 1, 4'b0010);
    chk("t3_up", 32'(o_up[0]), 1);
    chk("t3_noerr", 32'(o_err[0]), 0);
    chk("t3_frozen_bin", 32'(o_bin[1]), 2);

    // 4: non-adjacent error, snapshot kept, saturation
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 1, 4'b0100);
    chk("t4_code", 32'(o_code[0]), 1);
    chk("t4_bin", 32'(o_bin[0]), 7);
    step(0, 0, 1, 4'b0001);
    chk("t4_cnt2", 32'(o_cnt[0]), 2);
    chk("t4_scur", 32'(o_sc[0]), 4);
    chk("t4_code2", 32'(o_code[0]), 2);
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0000);
    for (int i = 0; i < 17; i++) step(0, 0, 1, (i % 2 == 0) ? 4'b0011 : 4'b0000);
    chk("t4_sat", 32'(o_cnt[0]), 15);
    chk("t4_halt_cnt", 32'(o_cnt[1]), 1);

    // 5: load re-arms without a check
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0001);
    step(0, 1, 1, 4'b0110);
    chk("t5_noerr", 32'(o_err[0]), 0);
    chk("t5_bin", 32'(o_bin[0]), 4);
    chk("t5_state", 32'(o_state[0]), 1);
    step(0, 1, 0, 4'b0000);
    chk("t5_idle", 32'(o_state[0]), 0);
    step(0, 0, 1, 4'b1111);
    chk("t5_noerr2", 32'(o_err[0]), 0);
    chk("t5_bin10", 32'(o_bin[0]), 10);

    // 6: halt, clear, async reset
    step(1, 0, 0, 4'b0000);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 1, 4'b0011);
    step(0, 0, 1, 4'b0001);
    step(0, 1, 1, 4'b0110);
    chk("t6_halt", 32'(o_state[1]), 2);
    chk("t6_frozen", 32'(o_bin[1]), 2);
    step(1, 0, 0, 4'b0000);
    chk("t6_clr_state", 32'(o_state[1]), 0);
    chk("t6_clr_cnt", 32'(o_cnt[1]), 0);
    chk("t6_clr_sticky", 32'(o_sticky[1]), 0);
    chk("t6_clr_keepbin", 32'(o_bin[1]), 2);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 1, 4'b0001);
    @(negedge clk); #1;
    rst_n = 1'b0; vld = 1'b0;
    #1;
    chk("t6_rst_state", 32'(o_state[1]), 0);
    chk("t6_rst_bin", 32'(o_bin[0]), 0);
    chk("t6_rst_up", 32'(o_up[1]), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    step(0, 0, 1, 4'b0101);
    chk("t6_ref_state", 32'(o_state[0]), 1);
    chk("t6_ref_bin", 32'(o_bin[0]), 6);
    chk("t6_ref_noup", 32'(o_up[0]), 0);
    step(0, 0, 0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic o_err_sticky_any();
    return o_sticky[0] | o_sticky[1];
  endfunction

endmodule
